// File: rtl/clkgen_multi.sv
// clkgen_multi: CH_NUM independent programmable clock dividers running off clkin.
// Each channel toggles clkout every `half` enabled clkin cycles. New half-periods
// are written into a pending slot and take effect only on a falling edge of
// that channel's output, so no period is ever truncated.
// Optional feature macro: CLKGEN_TICK_EN adds a per-channel `tick` pulse that is
// high on the cycle clkout rises.
module clkgen_multi #(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned CLKIN_FREQ = 50000000,
  parameter int unsigned DEF_FREQ   = 1000
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic [CH_NUM-1:0] clken,
  input  logic              sync_all,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic [CNT_W-1:0]  wr_half,
  output logic              wr_ack,
  output logic              wr_err,
  output logic [CH_NUM-1:0] pending,
  output logic [CH_NUM-1:0] clkout
`ifdef CLKGEN_TICK_EN
  ,
  output logic [CH_NUM-1:0] tick
`endif
);

  localparam int unsigned DEF_HALF = CLKIN_FREQ / 2 / DEF_FREQ;

  logic r_wr_ack;
  logic r_wr_err;
  logic w_wr_ok;

  // A write is legal only with a non-zero half-period to an existing channel.
  assign w_wr_ok = wr_en && (wr_half != '0) && ({1'b0, wr_ch} < 5'(CH_NUM));

  // Write handshake pulses; sync_all and rst swallow any concurrent write.
  always_ff @(posedge clkin) begin
    if (rst) begin
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
    end else if (sync_all) begin
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_ok;
      r_wr_err <= wr_en && !w_wr_ok;
    end
  end

  assign wr_ack = r_wr_ack;
  assign wr_err = r_wr_err;

  for (genvar g = 0; g < int'(CH_NUM); g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_nxt;
    logic             r_pending;
    logic             r_clkout;
    logic             r_tick;
    logic             w_sel;
    logic             w_toggle;

    assign w_sel    = w_wr_ok && (wr_ch == 4'(g));
    assign w_toggle = clken[g] && (r_cnt == (r_half - CNT_W'(1)));

    // Channel divider: count, toggle, apply pending half on falling edge, accept writes.
    always_ff @(posedge clkin) begin
      if (rst) begin
        r_cnt     <= '0;
        r_half    <= CNT_W'(DEF_HALF);
        r_nxt     <= CNT_W'(DEF_HALF);
        r_pending <= 1'b0;
        r_clkout  <= 1'b0;
        r_tick    <= 1'b0;
      end else if (sync_all) begin
        r_cnt     <= '0;
        r_clkout  <= 1'b0;
        r_tick    <= 1'b0;
        r_pending <= 1'b0;
        if (r_pending) begin
          r_half <= r_nxt;
        end
      end else begin
        r_tick <= 1'b0;
        if (w_toggle) begin
          r_cnt    <= '0;
          r_clkout <= ~r_clkout;
          r_tick   <= ~r_clkout;
          if (r_clkout && r_pending) begin
            r_half    <= r_nxt;
            r_pending <= 1'b0;
          end
        end else if (clken[g]) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        // Later assignment wins: a write coinciding with an apply stays pending.
        if (w_sel) begin
          r_nxt     <= wr_half;
          r_pending <= 1'b1;
        end
      end
    end

    assign clkout[g]  = r_clkout;
    assign pending[g] = r_pending;
`ifdef CLKGEN_TICK_EN
    assign tick[g]    = r_tick;
`else
    logic w_tick_unused;
    assign w_tick_unused = r_tick;
`endif
  end

endmodule

// File: doc/clkgen_multi.md
CLKGEN_MULTI -- requirements
Module: clkgen_multi

Interface
REQ-001 The module SHALL have parameter CH_NUM, default 4, meaning number of independent clock channels (1..16).
REQ-002 The module SHALL have parameter CNT_W, default 32, meaning width of the half-period counter and registers.
REQ-003 The module SHALL have parameter CLKIN_FREQ, default 50000000, meaning input clock frequency in Hz.
REQ-004 The module SHALL have parameter DEF_FREQ, default 1000, meaning reset output frequency in Hz; reset half-period DEF_HALF = CLKIN_FREQ/2/DEF_FREQ.
REQ-005 The module SHALL have port clkin, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have port clken, input, CH_NUM bits: per-channel count enable.
REQ-008 The module SHALL have port sync_all, input, 1 bit: phase-align all channels.
REQ-009 The module SHALL have port wr_en, input, 1 bit: half-period write request, one-cycle strobe.
REQ-010 The module SHALL have port wr_ch, input, 4 bits: target channel index.
REQ-011 The module SHALL have port wr_half, input, CNT_W bits: new half-period in clkin cycles.
REQ-012 The module SHALL have port wr_ack, output, 1 bit: write accepted pulse.
REQ-013 The module SHALL have port wr_err, output, 1 bit: write rejected pulse.
REQ-014 The module SHALL have port pending, output, CH_NUM bits: a written value awaits application.
REQ-015 The module SHALL have port clkout, output, CH_NUM bits: divided clocks, registered.

Function
REQ-016 Each channel SHALL hold counter cnt, active half-period half, pending value nxt and flag pending[i].
REQ-017 When clken[i]=1, cnt SHALL increment; on the enabled cycle where cnt = half-1, cnt SHALL become 0 and clkout[i] SHALL invert (half clkin cycles per level).
REQ-018 When clken[i]=0, cnt[i] and clkout[i] SHALL hold.
REQ-019 A write with wr_half≥1 and wr_ch<CH_NUM SHALL set nxt=wr_half, pending=1, and pulse wr_ack the following cycle.
REQ-020 A write with wr_half=0 or wr_ch≥CH_NUM SHALL change no state and pulse wr_err the following cycle.
REQ-021 A pending value SHALL be applied (half=nxt, pending cleared) only on a 1->0 toggle of clkout[i], so no truncated period is ever produced.
REQ-022 A write to a channel already pending SHALL overwrite nxt.
REQ-023 A write arriving on the same cycle as an applying 1->0 toggle SHALL apply the old nxt now and leave the new value pending.
REQ-024 sync_all=1 SHALL force every cnt to 0 and every clkout to 0, apply any pending values, and clear pending, regardless of clken.
REQ-025 rst SHALL have priority over sync_all, which SHALL have priority over writes and counting.

Reset
REQ-026 On rst=1 at a clkin edge: cnt=0, half=nxt=DEF_HALF, pending=0, clkout=0, wr_ack=wr_err=0 (and tick=0 when present).
REQ-027 Reset asserted mid-period or with a write in flight SHALL discard that write without wr_ack/wr_err.

Configuration
REQ-028 With macro CLKGEN_TICK_EN defined, the module SHALL add output tick, CH_NUM bits, pulsing for exactly one clkin cycle on the cycle clkout[i] becomes 1.
REQ-029 Without CLKGEN_TICK_EN, the tick port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 CLKIN_FREQ=100, DEF_FREQ=10, clken all 1 after reset -> every clkout toggles every 5 cycles, period 10.
REQ-031 Write ch1 half=3 mid-high-phase -> wr_ack next cycle, pending[1]=1, old period completes, then 3-cycle levels from the 1->0 edge.
REQ-032 Write wr_half=0, then wr_ch=7 with CH_NUM=4 -> wr_err pulses each time, no state change.
REQ-033 Drop clken[0] for 7 cycles mid-count -> clkout[0] and count freeze, resume with no lost or extra cycles.
REQ-034 Channels with halves 5 and 3 drifting, assert sync_all one cycle -> all clkout 0, next toggles 5 and 3 enabled cycles later.
REQ-035 With CLKGEN_TICK_EN, half=2 -> tick[i] single-cycle pulse every 4 cycles coincident with clkout rising.
